// File: rtl/conv_window_sequencer_pkg.sv
// Shared definitions for the 3x3 convolution window sequencer:
// FSM state encoding, kernel geometry and the tap-to-offset tables.
package conv_pkg;

    localparam int CONV_K    = 3;
    localparam int CONV_TAPS = CONV_K * CONV_K;

    localparam logic [3:0] LAST_TAP = 4'd8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Row offset (ky) and column offset (kx) of each kernel tap, raster order.
    localparam logic [1:0] TAP_KY [CONV_TAPS] = '{2'd0, 2'd0, 2'd0,
                                                  2'd1, 2'd1, 2'd1,
                                                  2'd2, 2'd2, 2'd2};
    localparam logic [1:0] TAP_KX [CONV_TAPS] = '{2'd0, 2'd1, 2'd2,
                                                  2'd0, 2'd1, 2'd2,
                                                  2'd0, 2'd1, 2'd2};

endpackage

// File: rtl/conv_window_sequencer_if.sv
// Handshake and address bus between the window sequencer, the layer
// control FSM, the feature-map memory, the MAC and the result register file.
interface conv_window_sequencer_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic              store_ready;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [3:0]        tap_idx;
    logic              mac_clr;
    logic              mac_en;
    logic              store;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        input  start, store_ready,
        output busy, done, rd_en, rd_addr, tap_idx, mac_clr, mac_en, store, out_addr
    );

    modport slave (
        output start, store_ready,
        input  busy, done, rd_en, rd_addr, tap_idx, mac_clr, mac_en, store, out_addr
    );
endinterface

// File: rtl/conv_window_sequencer_window_counter.sv
// Row/column position of the current 3x3 window. Advances in raster order
// on inc, wraps the column at COL_LAST and the row at ROW_LAST, and flags
// the final window of the channel.
module window_counter #(
    parameter int CNT_W    = 5,
    parameter int ROW_LAST = 25,
    parameter int COL_LAST = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] row,
    output logic [CNT_W-1:0] col,
    output logic             last
);
    localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(ROW_LAST);
    localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(COL_LAST);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    // Step to the next window position; a fresh pass starts at the origin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + ONE;
            end else begin
                col <= col + ONE;
            end
        end
    end

    assign last = (row == ROW_MAX) && (col == COL_MAX);

endmodule

// File: rtl/conv_window_sequencer.sv
// Walks every valid 3x3 window of an H x W channel, issuing nine reads per
// window, driving the MAC strobes one cycle behind the reads (memory has a
// one-cycle latency) and handing each output pixel over via store/store_ready.
module conv_window_sequencer
    import conv_pkg::*;
#(
    parameter int H      = 28,
    parameter int W      = 28,
    parameter int K      = 3,
    parameter int ADDR_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    conv_window_sequencer_if.master bus
);
    localparam int CNT_W    = $clog2(((H > W) ? H : W) + 1);
    localparam int ROW_LAST = H - K;
    localparam int COL_LAST = W - K;
    localparam int OUT_W    = W - K + 1;

    localparam logic [ADDR_W-1:0] W_A   = ADDR_W'(W);
    localparam logic [ADDR_W-1:0] OUT_A = ADDR_W'(OUT_W);

    state_t           state;
    state_t           next_state;
    logic [3:0]       tap;
    logic             mac_en_q;
    logic [3:0]       tap_q;
    logic             cnt_clear;
    logic             cnt_inc;
    logic             last_win;
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] col;

    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] pix_addr;

    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              store;
    logic [ADDR_W-1:0] out_addr;

    assign cnt_clear = (state == IDLE) && bus.start;
    assign cnt_inc   = (state == STORE) && bus.store_ready;

    window_counter #(
        .CNT_W    (CNT_W),
        .ROW_LAST (ROW_LAST),
        .COL_LAST (COL_LAST)
    ) u_window_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .row   (row),
        .col   (col),
        .last  (last_win)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: nine fetches, one drain, then wait for the store handshake.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = FETCH;
            FETCH:   if (tap == LAST_TAP) next_state = DRAIN;
            DRAIN:   next_state = STORE;
            STORE:   if (bus.store_ready) next_state = last_win ? DONE : FETCH;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Tap counter runs only while fetching and is back at 0 for the next window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap <= 4'd0;
        end else if (state == FETCH) begin
            tap <= (tap == LAST_TAP) ? 4'd0 : tap + 4'd1;
        end else begin
            tap <= 4'd0;
        end
    end

    // Delay the read strobe and tap by one cycle to line up with returning data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_en_q <= 1'b0;
            tap_q    <= 4'd0;
        end else begin
            mac_en_q <= (state == FETCH);
            tap_q    <= (state == FETCH) ? tap : 4'd0;
        end
    end

    // Feature-map address of the current tap and linear index of the output pixel.
    always_comb begin
        fetch_addr = (ADDR_W'(row) + ADDR_W'(TAP_KY[tap])) * W_A
                   + ADDR_W'(col) + ADDR_W'(TAP_KX[tap]);
        pix_addr   = ADDR_W'(row) * OUT_A + ADDR_W'(col);
    end

    // Output decode: every output is quiet unless its state is active.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        store    = 1'b0;
        out_addr = '0;
        case (state)
            FETCH: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                rd_addr = fetch_addr;
            end
            DRAIN: begin
                busy = 1'b1;
            end
            STORE: begin
                busy     = 1'b1;
                store    = 1'b1;
                out_addr = pix_addr;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.rd_en    = rd_en;
    assign bus.rd_addr  = rd_addr;
    assign bus.store    = store;
    assign bus.out_addr = out_addr;
    assign bus.mac_en   = mac_en_q;
    assign bus.tap_idx  = tap_q;
    assign bus.mac_clr  = mac_en_q && (tap_q == 4'd0);

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Self-checking bench for conv_window_sequencer: a queue-based model of the
// expected read/store streams plus handshake timing, driven by directed and
// randomized store_ready/start patterns.
module tb_conv_window_sequencer;
    localparam int H        = 28;
    localparam int W        = 28;
    localparam int K        = 3;
    localparam int ADDR_W   = 10;
    localparam int NWIN     = (H - K + 1) * (W - K + 1);
    localparam int PASS_CYC = 1 + NWIN * 11;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    conv_window_sequencer_if #(.ADDR_W(ADDR_W)) bus();

    conv_window_sequencer #(
        .H      (H),
        .W      (W),
        .K      (K),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit mon_on   = 1'b0;

    int exp_rd[$];
    int exp_st[$];
    bit m_idle   = 1'b1;
    bit m_busy   = 1'b0;
    bit m_done   = 1'b0;
    bit prev_rd  = 1'b0;
    int prev_tap = 0;
    int rd_in_win = 0;

    int start_cyc       = 0;
    int first_store_cyc = -1;
    int first_clr_cyc   = -1;
    int done_cyc        = -1;
    int done_count      = 0;
    int acc_count       = 0;
    int stall_cnt       = 0;

    // Free-running cycle number used to time events relative to start.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    task automatic checkAllZero(input string pfx);
        checkOutput({pfx, "_busy"},     bus.busy,     0);
        checkOutput({pfx, "_done"},     bus.done,     0);
        checkOutput({pfx, "_rd_en"},    bus.rd_en,    0);
        checkOutput({pfx, "_rd_addr"},  bus.rd_addr,  0);
        checkOutput({pfx, "_tap_idx"},  bus.tap_idx,  0);
        checkOutput({pfx, "_mac_clr"},  bus.mac_clr,  0);
        checkOutput({pfx, "_mac_en"},   bus.mac_en,   0);
        checkOutput({pfx, "_store"},    bus.store,    0);
        checkOutput({pfx, "_out_addr"}, bus.out_addr, 0);
    endtask

    // Expected streams for one pass, straight from the window/tap definition.
    task automatic loadModel();
        exp_rd.delete();
        exp_st.delete();
        for (int r = 0; r <= H - K; r++) begin
            for (int c = 0; c <= W - K; c++) begin
                exp_st.push_back(r * (W - K + 1) + c);
                for (int t = 0; t < K * K; t++) begin
                    exp_rd.push_back((r + t / K) * W + c + t % K);
                end
            end
        end
    endtask

    // Per-cycle monitor: compares outputs with the model, then advances the model.
    always @(negedge clk) begin : monitor
        bit start_hit;
        bit acc_last;
        int cur_tap;
        if (rst) begin
            m_idle    = 1'b1;
            m_busy    = 1'b0;
            m_done    = 1'b0;
            prev_rd   = 1'b0;
            prev_tap  = 0;
            rd_in_win = 0;
            exp_rd.delete();
            exp_st.delete();
        end else if (mon_on) begin
            acc_last = 1'b0;
            cur_tap  = 0;

            checkOutput("busy", bus.busy, m_busy);
            checkOutput("done", bus.done, m_done);
            if (bus.done) begin
                done_count++;
                done_cyc = cyc;
            end

            if (bus.rd_en) begin
                if (exp_rd.size() == 0) checkOutput("rd_unexpected", 1, 0);
                else checkOutput("rd_addr", bus.rd_addr, exp_rd.pop_front());
                cur_tap   = rd_in_win;
                rd_in_win = (rd_in_win == K * K - 1) ? 0 : rd_in_win + 1;
            end

            checkOutput("mac_en", bus.mac_en, prev_rd);
            if (prev_rd) begin
                checkOutput("tap_idx", bus.tap_idx, prev_tap);
                checkOutput("mac_clr", bus.mac_clr, (prev_tap == 0));
            end else begin
                checkOutput("mac_clr_off", bus.mac_clr, 0);
            end
            if (bus.mac_clr && first_clr_cyc < 0) first_clr_cyc = cyc;
            prev_rd  = bus.rd_en;
            prev_tap = cur_tap;

            if (bus.store) begin
                checkOutput("rd_en_in_store", bus.rd_en, 0);
                if (first_store_cyc < 0) first_store_cyc = cyc;
                if (exp_st.size() == 0) begin
                    checkOutput("store_unexpected", 1, 0);
                end else begin
                    checkOutput("out_addr", bus.out_addr, exp_st[0]);
                    if (bus.store_ready) begin
                        void'(exp_st.pop_front());
                        acc_count++;
                        acc_last = (exp_st.size() == 0);
                    end else begin
                        stall_cnt++;
                    end
                end
            end

            start_hit = m_idle && bus.start;
            if (m_done) m_idle = 1'b1;
            m_done = acc_last;
            if (acc_last) m_busy = 1'b0;
            if (start_hit) begin
                m_idle          = 1'b0;
                m_busy          = 1'b1;
                loadModel();
                start_cyc       = cyc;
                first_store_cyc = -1;
                first_clr_cyc   = -1;
                acc_count       = 0;
                stall_cnt       = 0;
                rd_in_win       = 0;
            end
        end
    end

    task automatic startPass();
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // mode 0: ready high, extra starts mid-pass and on the done cycle
    // mode 1: ready low for 5 STORE cycles on window 3
    // mode 2: random ready and random mid-pass starts
    task automatic applyStimulus(input int mode);
        int base_done;
        int guard;
        int stall_state;
        int lows;
        base_done   = done_count;
        guard       = 0;
        stall_state = 0;
        lows        = 0;
        bus.store_ready = 1'b1;
        startPass();
        while (done_count == base_done && guard < PASS_CYC + 4000) begin
            @(posedge clk); #1;
            guard++;
            case (mode)
                0: begin
                    bus.store_ready = 1'b1;
                    bus.start = (cyc == start_cyc + 3000) || (cyc == start_cyc + PASS_CYC);
                end
                1: begin
                    if (stall_state == 0 && acc_count >= 3) begin
                        bus.store_ready = 1'b0;
                        stall_state = 1;
                    end else if (stall_state == 1 && bus.store) begin
                        lows++;
                        if (lows == 5) stall_state = 2;
                    end else if (stall_state == 2) begin
                        bus.store_ready = 1'b1;
                        stall_state = 3;
                    end
                end
                default: begin
                    bus.store_ready = ($urandom_range(0, 3) != 0);
                    bus.start = (cyc - start_cyc > 100) && (cyc - start_cyc < 5000)
                                && ($urandom_range(0, 199) == 0);
                end
            endcase
        end
        bus.start = 1'b0;
        bus.store_ready = 1'b1;
        checkOutput("done_seen", done_count - base_done, 1);
        checkOutput("store_count", acc_count, NWIN);
        case (mode)
            0: begin
                checkOutput("done_latency", done_cyc - start_cyc, PASS_CYC);
                checkOutput("first_store_cyc", first_store_cyc - start_cyc, 11);
                checkOutput("first_clr_cyc", first_clr_cyc - start_cyc, 2);
            end
            1: checkOutput("done_latency_stall", done_cyc - start_cyc, PASS_CYC + 5);
            default: checkOutput("done_latency_rand", done_cyc - start_cyc, PASS_CYC + stall_cnt);
        endcase
        repeat (6) @(posedge clk);
        #1;
        checkOutput("done_single", done_count - base_done, 1);
        checkOutput("idle_busy", bus.busy, 0);
    endtask

    task automatic resetMidPass();
        int guard;
        guard = 0;
        bus.store_ready = 1'b1;
        startPass();
        while (acc_count < 100 && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("reached_window_100", acc_count, 100);
        repeat (3) begin
            @(posedge clk); #1;
        end
        checkOutput("fetch_before_reset", bus.rd_en, 1);
        rst = 1'b1;
        #1;
        checkAllZero("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkAllZero("after_rst");
    endtask

    initial begin
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.store_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;
        bus.store_ready = 1'b1;
        mon_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] full pass with extra start pulses");
        applyStimulus(0);
        $display("[TB] pass with store_ready stall on window 3");
        applyStimulus(1);
        $display("[TB] reset during window 100");
        resetMidPass();
        $display("[TB] pass with random store_ready");
        applyStimulus(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
